pipe_reg_chain: RTL and testbench

Parametrised elastic pipeline register: a chain of DEPTH registered stages of WIDTH bits, each carrying a valid bit. Words move forward under a valid/ready handshake, and the chain supports stall, bubble collapse and synchronous flush. It is the general-purpose stage register between datapath units in the pipelined processor, replacing fixed-width, always-enabled D registers wherever stalls or flushes are needed.

---
 rtl/pipe_reg_chain.sv | 84 ++++++++
 tb/tb_pipe_reg_chain.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: elastic pipeline register of DEPTH valid-tagged stages.
// Words advance under valid/ready. Empty stages always accept, so bubbles
// collapse behind a stalled output. A synchronous flush clears every valid bit.
module pipe_reg_chain #(
    parameter int unsigned      WIDTH       = 16,
    parameter int unsigned      DEPTH       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] v_nxt;
    logic [DEPTH-1:0] adv;
    logic [WIDTH-1:0] d [DEPTH];
    logic [CW-1:0]    cnt_nxt;

    // Advance terms ripple from the output stage back toward the input.
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = !v[DEPTH-1] | out_ready;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            adv[DEPTH-1-k] = !v[DEPTH-1-k] | adv[DEPTH-k];
        end
    end

    // Next valid vector and its population, so count lands on the same edge as v.
    always_comb begin
        v_nxt   = v;
        cnt_nxt = '0;
        if (flush) begin
            v_nxt = '0;
        end else begin
            if (adv[0]) v_nxt[0] = in_valid;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if (adv[i]) v_nxt[i] = v[i-1];
            end
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            cnt_nxt = cnt_nxt + CW'(v_nxt[i]);
        end
    end

    // Valid bits and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v     <= '0;
            count <= '0;
        end else begin
            v     <= v_nxt;
            count <= cnt_nxt;
        end
    end

    // Data registers load only when a valid word moves in; bubbles keep old data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                d[i] <= RESET_VALUE;
            end
        end else if (!flush) begin
            if (adv[0] && in_valid) d[0] <= in_data;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if (adv[i] && v[i-1]) d[i] <= d[i-1];
            end
        end
    end

    assign in_ready  = adv[0] & !flush;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: scoreboard bench for pipe_reg_chain (WIDTH=16, DEPTH=3).
// The reference is an in-order word queue: accepts push, emits pop, flush and
// reset empty it; the queue size is the expected occupancy.
module tb_pipe_reg_chain;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             flush = 1'b0;
    logic [1:0]       count;

    int n_cmp = 0;
    int n_bad = 0;
    logic [WIDTH-1:0] exp_q [$];

    pipe_reg_chain #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .RESET_VALUE (16'h0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (DEPTH + 2) step();
    endtask

    // Monitor: samples mid-cycle, checks against the queue model, then applies
    // the events that the coming edge will commit.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
            end else begin
                chk("count", {30'd0, count}, exp_q.size());
                chk("in_ready", {31'd0, in_ready},
                    {31'd0, (!flush && (exp_q.size() < DEPTH || out_ready))});
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) chk("emit_unexpected", {31'd0, out_valid}, 32'd0);
                    else chk("out_data", {16'd0, out_data}, {16'd0, exp_q.pop_front()});
                end else if (exp_q.size() == 0) begin
                    chk("out_valid_empty", {31'd0, out_valid}, 32'd0);
                end
                if (in_valid && in_ready) exp_q.push_back(in_data);
                if (flush) exp_q.delete();
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {16'd0, out_data}, 32'd0);
        chk("rst_count", {30'd0, count}, 32'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Asynchronous reset mid-stream.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hE001; step();
        in_data   = 16'hE002; step();
        in_valid  = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("amid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("amid_out_data", {16'd0, out_data}, 32'd0);
        chk("amid_count", {30'd0, count}, 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'hF001;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            step();
            lat++;
        end
        chk("post_rst_latency", lat, DEPTH);
        chk("post_rst_data", {16'd0, out_data}, 32'h0000F001);
        drain();

        // Streaming.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h1111; step();
        chk("stream_e1", {31'd0, out_valid}, 32'd0);
        in_data   = 16'h2222; step();
        chk("stream_e2", {31'd0, out_valid}, 32'd0);
        in_data   = 16'h3333; step();
        in_valid  = 1'b0;
        chk("stream_w1", {15'd0, out_valid, out_data}, 32'h00011111); step();
        chk("stream_w2", {15'd0, out_valid, out_data}, 32'h00012222); step();
        chk("stream_w3", {15'd0, out_valid, out_data}, 32'h00013333); step();
        chk("stream_end", {31'd0, out_valid}, 32'd0);
        drain();

        // Backpressure.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            in_data = 16'hA000 + 16'(k);
            #1;
            chk("bp_fill_ready", {31'd0, in_ready}, 32'd1);
            step();
        end
        in_data = 16'hA004;
        repeat (2) begin
            #1;
            chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
            step();
        end
        chk("bp_count", {30'd0, count}, 32'd3);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_gap0", {31'd0, out_valid}, 32'd1);
        step();
        in_data = 16'hA005;
        chk("bp_gap1", {31'd0, out_valid}, 32'd1);
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("bp_gap", {31'd0, out_valid}, 32'd1);
            step();
        end
        chk("bp_empty", {31'd0, out_valid}, 32'd0);
        drain();

        // Bubble collapse.
        out_ready = 1'b0;
        in_valid  = 1'b1; in_data = 16'hB001; step();
        in_valid  = 1'b0; step();
        in_valid  = 1'b1; in_data = 16'hB002; step();
        in_valid  = 1'b0; step(); step();
        chk("bub_count", {30'd0, count}, 32'd2);
        chk("bub_head", {15'd0, out_valid, out_data}, 32'h0001B001);
        out_ready = 1'b1;
        step();
        chk("bub_next", {15'd0, out_valid, out_data}, 32'h0001B002);
        step();
        chk("bub_empty", {31'd0, out_valid}, 32'd0);
        drain();

        // Flush of a full chain.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hC001; step();
        in_data   = 16'hC002; step();
        in_data   = 16'hC003; step();
        flush     = 1'b1;
        in_data   = 16'hC004;
        #1;
        chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_count", {30'd0, count}, 32'd0);
        chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_out_data", {16'd0, out_data}, 32'h0000C001);
        out_ready = 1'b1;
        repeat (4) begin
            step();
            chk("fl_no_c004", {31'd0, out_valid}, 32'd0);
        end

        // Full chain with simultaneous accept and emit.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            in_data = 16'hD000 + 16'(k);
            step();
        end
        out_ready = 1'b1;
        for (int k = 4; k <= 7; k++) begin
            in_data = 16'hD000 + 16'(k);
            step();
            chk("full_count", {30'd0, count}, 32'd3);
        end
        drain();

        // Randomized traffic, including occasional flushes.
        for (int c = 0; c < 500; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            step();
        end
        drain();
        chk("final_count", {30'd0, count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
